instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage feeding the multicycle control unit and datapath. Owns the PC and the
//  instruction register (IR), and issues one instruction-memory read per fetch_en
//  (the control unit's fetch state) over a req/ack handshake. Holds the IR stable
//  for all decode/execute cycles, and loads the next PC on pc_update per pc_select.
// PARAMETERS
//  RESET_VECTOR  32'h0100_0000  PC after reset and for pc_select==2
//  TIMEOUT       16             max cycles imem_req may wait for imem_ack (>=1)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   synchronous reset, active-low (0 = reset)
//  fetch_en     in   1   start fetch at current pc (pulse or level)
//  pc_update    in   1   1-cycle pulse: load next pc per pc_select
//  pc_select    in   2   0=alu_out 1=pc+4 2=RESET_VECTOR 3=hold
//  alu_out      in   32  branch/jump target from ALU
//  imem_req     out  1   read request, held until imem_ack
//  imem_addr    out  32  read address (== pc while imem_req)
//  imem_ack     in   1   read complete; imem_rdata/imem_err valid this cycle
//  imem_rdata   in   32  instruction word
//  imem_err     in   1   bus error, qualified by imem_ack
//  instruction  out  32  instruction register
//  instr_valid  out  1   IR holds a valid word for current pc
//  pc           out  32  current PC
//  pc_plus4     out  32  pc + 4 (mod 2^32), combinational
//  fetch_busy   out  1   fetch in progress (state REQ)
//  fetch_fault  out  1   sticky fault flag
//  fault_cause  out  2   0=none 1=bus error 2=timeout 3=misaligned pc
// BEHAVIOUR
//  Reset (rst==0 at edge): pc=RESET_VECTOR, instruction=32'h0000_0013 (NOP),
//   instr_valid=0, imem_req=0, imem_addr=0, fetch_busy=0, fetch_fault=0,
//   fault_cause=0, timeout counter=0, state=IDLE. Reset overrides any state,
//   including mid-handshake; a late imem_ack after reset is ignored.
//  FSM IDLE/REQ/FAULT; all outputs except pc_plus4 registered.
//  IDLE: pc_update has priority: pc loads next value, instr_valid<=0, fetch_en that
//   cycle is dropped. Else fetch_en: if pc[1:0]!=0 -> FAULT cause 3; else -> REQ with
//   imem_req<=1, imem_addr<=pc, counter<=0.
//  REQ: imem_req/imem_addr stable until ack. imem_ack&!imem_err: instruction<=
//   imem_rdata, instr_valid<=1, imem_req<=0 -> IDLE. imem_ack&imem_err: IR unchanged,
//   instr_valid<=0 -> FAULT cause 1. No ack and counter==TIMEOUT-1: imem_req<=0 ->
//   FAULT cause 2; otherwise counter++. pc_update and fetch_en ignored in REQ.
//  Latency: fetch_en at edge N -> imem_req high after N; ack at edge M -> instr_valid,
//   instruction updated after M. Zero-wait memory: 2 edges fetch_en->valid.
//  instr_valid stays 1 and IR stays constant until pc_update or a new fetch completes.
//   A new fetch_en with instr_valid=1 refetches; instr_valid stays 1 until capture.
//  FAULT: imem_req=0, instr_valid=0, fetch_fault=1, cause frozen; fetch_en ignored.
//   Exit only via pc_update with pc_select==2 (pc<=RESET_VECTOR, fault/cause cleared
//   -> IDLE) or reset. pc_update with other selects is ignored in FAULT.
//  pc_select 0 takes alu_out verbatim; misalignment is detected at the next fetch.
//   pc_select 3 leaves pc unchanged but still clears instr_valid.
//  pc+4 wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
// TESTING
//  1 Reset, fetch_en 1 cycle, ack next cycle with rdata=32'h0000_0093 -> imem_addr=
//    32'h0100_0000, instr_valid=1 and instruction=32'h0000_0093 two edges after fetch_en.
//  2 ack delayed 5 cycles -> imem_req/imem_addr stable 6 cycles, busy=1 throughout,
//    single capture; pc_update pulsed mid-wait leaves pc unchanged.
//  3 pc_update pc_select=1 at pc=32'hFFFF_FFFC -> pc=0, instr_valid=0; pc_select=0,
//    alu_out=32'h0100_0040 -> pc=32'h0100_0040; pc_select=3 -> pc unchanged.
//  4 Never ack -> after TIMEOUT=16 cycles imem_req drops, fetch_fault=1, cause=2;
//    fetch_en ignored; pc_update pc_select=2 -> fault cleared, pc=RESET_VECTOR.
//  5 ack with imem_err=1 -> cause=1, IR keeps old word; alu_out=32'h0100_0042 via
//    pc_select=0 then fetch_en -> no imem_req, cause=3.
//  6 rst=0 during REQ wait, ack arrives after release -> all outputs at reset
//    values, IR stays NOP, instr_valid=0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
//   imem_req    fetch unit -> memory  read request, held until imem_ack
//   imem_addr   fetch unit -> memory  read address (valid while imem_req)
//   imem_ack    memory -> fetch unit  read complete this cycle
//   imem_rdata  memory -> fetch unit  instruction word, qualified by imem_ack
//   imem_err    memory -> fetch unit  bus error, qualified by imem_ack
// master: fetch-unit side; slave: memory side.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    input  imem_err
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    output imem_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage for the multicycle core. Owns PC and instruction register,
// issues one instruction-memory read per fetch_en over a req/ack handshake,
// and loads the next PC on pc_update according to pc_select.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-low
//   fetch_en     start a fetch at the current pc
//   pc_update    1-cycle pulse: load next pc per pc_select
//   pc_select    0=alu_out 1=pc+4 2=RESET_VECTOR 3=hold
//   alu_out      branch/jump target
//   imem         instruction-memory bus (master side)
//   instruction  instruction register
//   instr_valid  IR holds a valid word for the current pc
//   pc           current PC
//   pc_plus4     pc + 4, combinational
//   fetch_busy   fetch in progress
//   fetch_fault  sticky fault flag
//   fault_cause  0=none 1=bus error 2=timeout 3=misaligned pc
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0100_0000,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  input  logic                       pc_update,
  input  logic [1:0]                 pc_select,
  input  logic [31:0]                alu_out,
  instr_fetch_unit_if.master         imem,
  output logic [31:0]                instruction,
  output logic                       instr_valid,
  output logic [31:0]                pc,
  output logic [31:0]                pc_plus4,
  output logic                       fetch_busy,
  output logic                       fetch_fault,
  output logic [1:0]                 fault_cause
);

  localparam int unsigned CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, FAULT} state_t;

  state_t        state, state_nx;
  logic [31:0]   pc_q, pc_nx;
  logic [31:0]   ir_q, ir_nx;
  logic [31:0]   addr_q, addr_nx;
  logic          valid_q, valid_nx;
  logic          req_q, req_nx;
  logic          fault_q, fault_nx;
  logic [1:0]    cause_q, cause_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [31:0]   pc_inc;
  logic [31:0]   next_pc;

  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    next_pc = pc_q;
    case (pc_select)
      2'd0:    next_pc = alu_out;
      2'd1:    next_pc = pc_inc;
      2'd2:    next_pc = RESET_VECTOR;
      default: next_pc = pc_q;
    endcase
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc_q;
    ir_nx    = ir_q;
    addr_nx  = addr_q;
    valid_nx = valid_q;
    req_nx   = req_q;
    fault_nx = fault_q;
    cause_nx = cause_q;
    cnt_nx   = cnt_q;
    case (state)
      IDLE: begin
        if (pc_update) begin
          pc_nx    = next_pc;
          valid_nx = 1'b0;
        end else if (fetch_en) begin
          if (pc_q[1:0] != 2'b00) begin
            state_nx = FAULT;
            fault_nx = 1'b1;
            cause_nx = 2'd3;
            valid_nx = 1'b0;
          end else begin
            // instr_valid is left as-is: a refetch keeps the old word valid until capture
            state_nx = REQ;
            req_nx   = 1'b1;
            addr_nx  = pc_q;
            cnt_nx   = '0;
          end
        end
      end
      REQ: begin
        if (imem.imem_ack) begin
          req_nx = 1'b0;
          if (imem.imem_err) begin
            state_nx = FAULT;
            valid_nx = 1'b0;
            fault_nx = 1'b1;
            cause_nx = 2'd1;
          end else begin
            state_nx = IDLE;
            ir_nx    = imem.imem_rdata;
            valid_nx = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_nx = FAULT;
          req_nx   = 1'b0;
          valid_nx = 1'b0;
          fault_nx = 1'b1;
          cause_nx = 2'd2;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      FAULT: begin
        if (pc_update && (pc_select == 2'd2)) begin
          state_nx = IDLE;
          pc_nx    = RESET_VECTOR;
          fault_nx = 1'b0;
          cause_nx = 2'd0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      pc_q    <= RESET_VECTOR;
      ir_q    <= NOP;
      addr_q  <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nx;
      pc_q    <= pc_nx;
      ir_q    <= ir_nx;
      addr_q  <= addr_nx;
      valid_q <= valid_nx;
      req_q   <= req_nx;
      fault_q <= fault_nx;
      cause_q <= cause_nx;
      cnt_q   <= cnt_nx;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign instruction    = ir_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_inc;
  assign fetch_busy     = req_q;
  assign fetch_fault    = fault_q;
  assign fault_cause    = cause_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed stimulus pushes expected request
// addresses and transaction outcomes into queues; a monitor pops and
// compares whenever a request starts or a fetch ends.
module tb_instr_fetch_unit;
  localparam logic [31:0] RV  = 32'h0100_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] pc;
  } done_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0;
  logic        pc_update = 1'b0;
  logic [1:0]  pc_select = 2'd3;
  logic [31:0] alu_out = '0;
  logic [31:0] instruction, pc, pc_plus4;
  logic        instr_valid, fetch_busy, fetch_fault;
  logic [1:0]  fault_cause;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_VECTOR(RV), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_update(pc_update),
    .pc_select(pc_select), .alu_out(alu_out), .imem(bus.master),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .pc_plus4(pc_plus4), .fetch_busy(fetch_busy), .fetch_fault(fetch_fault),
    .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] req_q[$];
  done_t       done_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  logic        prev_req = 1'b0, prev_fault = 1'b0;
  logic [31:0] held_addr = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (bus.imem_req && !prev_req) begin
          if (req_q.size() == 0) begin
            chk("unexpected_req", 32'd1, 32'd0);
          end else begin
            held_addr = req_q.pop_front();
            chk("req_addr", bus.imem_addr, held_addr);
          end
        end else if (bus.imem_req && prev_req) begin
          chk("req_addr_stable", bus.imem_addr, held_addr);
          chk("busy_during_req", {31'd0, fetch_busy}, 32'd1);
        end
        if ((prev_req && !bus.imem_req) || (fetch_fault && !prev_fault)) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            done_t e;
            e = done_q.pop_front();
            chk("done_instr", instruction, e.instr);
            chk("done_valid", {31'd0, instr_valid}, {31'd0, e.valid});
            chk("done_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
            chk("done_cause", {30'd0, fault_cause}, {30'd0, e.cause});
            chk("done_pc", pc, e.pc);
          end
        end
      end
      prev_req   = bus.imem_req;
      prev_fault = fetch_fault;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse fetch_en; ack arrives 'delay' cycles after the request is raised.
  task automatic fetch(input int delay, input logic [31:0] rdata, input logic err);
    tick(); fetch_en = 1'b1;
    tick(); fetch_en = 1'b0;
    repeat (delay) tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = rdata; bus.imem_err = err;
    tick(); bus.imem_ack = 1'b0; bus.imem_err = 1'b0;
  endtask

  task automatic pc_upd(input logic [1:0] sel, input logic [31:0] tgt);
    tick(); pc_update = 1'b1; pc_select = sel; alu_out = tgt;
    tick(); pc_update = 1'b0; pc_select = 2'd3;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, pc, RV);
    chk({tag, "_ir"}, instruction, NOP);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_req"}, {31'd0, bus.imem_req}, 32'd0);
    chk({tag, "_busy"}, {31'd0, fetch_busy}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
    chk({tag, "_cause"}, {30'd0, fault_cause}, 32'd0);
  endtask

  initial begin
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.imem_err = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    chk_reset_state("rst");
    chk("rst_addr", bus.imem_addr, 32'd0);

    // 1: zero-wait fetch
    req_q.push_back(RV);
    done_q.push_back('{instr: 32'h0000_0093, valid: 1'b1, fault: 1'b0, cause: 2'd0, pc: RV});
    fetch(0, 32'h0000_0093, 1'b0);
    chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_ir", instruction, 32'h0000_0093);

    // 2: refetch with 5-cycle ack delay, pc_update ignored mid-wait
    req_q.push_back(RV);
    done_q.push_back('{instr: 32'h0010_0113, valid: 1'b1, fault: 1'b0, cause: 2'd0, pc: RV});
    tick(); fetch_en = 1'b1;
    tick(); fetch_en = 1'b0;
    tick();
    tick(); pc_update = 1'b1; pc_select = 2'd0; alu_out = 32'h1234_5678;
    tick(); pc_update = 1'b0; pc_select = 2'd3;
    chk("t2_pc_held", pc, RV);
    chk("t2_valid_held", {31'd0, instr_valid}, 32'd1);
    tick();
    tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0010_0113;
    tick(); bus.imem_ack = 1'b0;

    // 3: pc_select paths and wrap
    pc_upd(2'd0, 32'hFFFF_FFFC);
    chk("t3_pc_alu", pc, 32'hFFFF_FFFC);
    chk("t3_pc4_wrap", pc_plus4, 32'h0000_0000);
    chk("t3_valid_clr", {31'd0, instr_valid}, 32'd0);
    pc_upd(2'd1, 32'h0);
    chk("t3_pc_wrap", pc, 32'h0000_0000);
    chk("t3_pc4", pc_plus4, 32'h0000_0004);
    pc_upd(2'd0, 32'h0100_0040);
    chk("t3_pc_tgt", pc, 32'h0100_0040);
    req_q.push_back(32'h0100_0040);
    done_q.push_back('{instr: 32'h0000_0033, valid: 1'b1, fault: 1'b0, cause: 2'd0, pc: 32'h0100_0040});
    fetch(0, 32'h0000_0033, 1'b0);
    pc_upd(2'd3, 32'hDEAD_0000);
    chk("t3_pc_hold", pc, 32'h0100_0040);
    chk("t3_hold_valid", {31'd0, instr_valid}, 32'd0);

    // 4: timeout
    req_q.push_back(32'h0100_0040);
    done_q.push_back('{instr: 32'h0000_0033, valid: 1'b0, fault: 1'b1, cause: 2'd2, pc: 32'h0100_0040});
    tick(); fetch_en = 1'b1;
    tick(); fetch_en = 1'b0;
    repeat (15) tick();
    chk("t4_req_before_to", {31'd0, bus.imem_req}, 32'd1);
    tick();
    chk("t4_req_after_to", {31'd0, bus.imem_req}, 32'd0);
    chk("t4_fault", {31'd0, fetch_fault}, 32'd1);
    fetch_en = 1'b1;
    tick(); tick(); fetch_en = 1'b0;
    chk("t4_fetch_ignored", {31'd0, bus.imem_req}, 32'd0);
    chk("t4_cause_frozen", {30'd0, fault_cause}, 32'd2);
    pc_upd(2'd0, 32'h0000_0100);
    chk("t4_upd_ignored_pc", pc, 32'h0100_0040);
    chk("t4_upd_ignored_flt", {31'd0, fetch_fault}, 32'd1);
    pc_upd(2'd2, 32'h0);
    chk("t4_exit_pc", pc, RV);
    chk("t4_exit_fault", {31'd0, fetch_fault}, 32'd0);
    chk("t4_exit_cause", {30'd0, fault_cause}, 32'd0);

    // 5: bus error, then misaligned pc
    req_q.push_back(RV);
    done_q.push_back('{instr: 32'h0000_0033, valid: 1'b0, fault: 1'b1, cause: 2'd1, pc: RV});
    fetch(1, 32'h0BAD_0BAD, 1'b1);
    pc_upd(2'd2, 32'h0);
    pc_upd(2'd0, 32'h0100_0042);
    done_q.push_back('{instr: 32'h0000_0033, valid: 1'b0, fault: 1'b1, cause: 2'd3, pc: 32'h0100_0042});
    tick(); fetch_en = 1'b1;
    tick(); fetch_en = 1'b0;
    chk("t5_no_req", {31'd0, bus.imem_req}, 32'd0);
    chk("t5_cause", {30'd0, fault_cause}, 32'd3);
    pc_upd(2'd2, 32'h0);

    // 6: reset during request wait, late ack ignored
    req_q.push_back(RV);
    tick(); fetch_en = 1'b1;
    tick(); fetch_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick(); bus.imem_ack = 1'b0;
    tick();
    chk_reset_state("t6");

    chk("req_q_empty", req_q.size(), 32'd0);
    chk("done_q_empty", done_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
